// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry,
// startup state encoding, forward-select encoding and the PC register address.
package pipe_ctrl_pkg;

    // Widest register address the scoreboard entry can hold; narrower
    // addresses are zero-extended into the rd field.
    localparam int REG_AW_MAX = 8;

    // Forward select value meaning "read the register file".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic                  ld;
        logic [REG_AW_MAX-1:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } boot_state_e;

    // All-ones address of width reg_aw: the PC, which is never forwarded.
    function automatic logic [REG_AW_MAX-1:0] PC_ADDR(input int reg_aw);
        PC_ADDR = '0;
        for (int i = 0; i < REG_AW_MAX; i++) begin
            if (i < reg_aw) PC_ADDR[i] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source scoreboard lookup: finds the youngest in-flight writer of one
// source register and reports its forward select and whether it is a load
// whose data is not yet forwardable.
module hazard_match
    import pipe_ctrl_pkg::*;
#(
    parameter int N_STAGES = 4,
    parameter int REG_AW   = 4,
    parameter int LOAD_LAT = 2,
    parameter int SELW     = $clog2(N_STAGES + 1)
) (
    input  sb_entry_t         sb_i [N_STAGES],
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic              src_used_i,
    output logic [SELW-1:0]   sel_o,
    output logic              load_hit_o
);

    logic [REG_AW_MAX-1:0] src_ext;
    logic                  found;

    // Youngest-first priority search; the first hit decides both outputs.
    always_comb begin
        src_ext             = '0;
        src_ext[REG_AW-1:0] = src_addr_i;
        sel_o               = SELW'(FWD_RF);
        load_hit_o          = 1'b0;
        found               = 1'b0;
        if (src_used_i && (src_ext != PC_ADDR(REG_AW))) begin
            for (int k = 0; k < N_STAGES; k++) begin
                if (!found && sb_i[k].valid && sb_i[k].wr && (sb_i[k].rd == src_ext)) begin
                    found      = 1'b1;
                    sel_o      = SELW'(k + 1);
                    load_hit_o = sb_i[k].ld && (k < LOAD_LAT);
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Scoreboard / hazard controller for the in-order pipeline: tracks in-flight
// writers, drives forward selects, load-use stall, epoch-based redirect
// flush and the startup PC-load sequence.
// Optional build macro HAZARD_PERF_EN adds saturating stall/redirect counters.
//
// state | meaning
// BOOT  | one cycle, PC loads the reset vector
// FILL  | FETCH_LAT cycles waiting for the first fetched instruction
// RUN   | normal operation (terminal until reset)
module pipeline_hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int N_STAGES  = 4,
    parameter int REG_AW    = 4,
    parameter int N_SRC     = 3,
    parameter int LOAD_LAT  = 2,
    parameter int FETCH_LAT = 2,
    parameter int EPOCH_W   = 2,
    localparam int SELW     = $clog2(N_STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid_i,
    input  logic [EPOCH_W-1:0]      issue_epoch_i,
    input  logic                    issue_wr_i,
    input  logic                    issue_ld_i,
    input  logic [REG_AW-1:0]       issue_rd_i,
    input  logic [N_SRC*REG_AW-1:0] src_addr_i,
    input  logic [N_SRC-1:0]        src_used_i,
    input  logic                    redirect_i,
    output logic                    sel_pc_start_o,
    output logic                    load_pc_o,
    output logic                    issue_ready_o,
    output logic                    stall_o,
    output logic                    flush_o,
    output logic [EPOCH_W-1:0]      epoch_o,
    output logic [N_SRC*SELW-1:0]   fwd_sel_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]             perf_stall_o,
    output logic [31:0]             perf_flush_o
`endif
);

    localparam int CNT_W = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

    boot_state_e          state_q, state_d;
    logic [CNT_W-1:0]     fill_cnt_q, fill_cnt_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;
    logic                 flush_q, flush_d;
    sb_entry_t            sb_q [N_STAGES];
    sb_entry_t            sb_d [N_STAGES];

    logic [N_SRC-1:0]     load_hit;
    logic                 in_run;
    logic                 redirect_eff;
    logic                 accept;

    for (genvar j = 0; j < N_SRC; j++) begin : g_match
        hazard_match #(
            .N_STAGES (N_STAGES),
            .REG_AW   (REG_AW),
            .LOAD_LAT (LOAD_LAT),
            .SELW     (SELW)
        ) u_match (
            .sb_i       (sb_q),
            .src_addr_i (src_addr_i[j*REG_AW +: REG_AW]),
            .src_used_i (src_used_i[j]),
            .sel_o      (fwd_sel_o[j*SELW +: SELW]),
            .load_hit_o (load_hit[j])
        );
    end

    // Issue handshake, stall and PC control; a redirect overrides a load-use stall.
    always_comb begin
        in_run         = (state_q == RUN);
        redirect_eff   = redirect_i && in_run;
        stall_o        = (|load_hit) && !redirect_eff;
        issue_ready_o  = in_run && !stall_o;
        accept         = issue_valid_i && issue_ready_o
                         && (issue_epoch_i == epoch_q) && !redirect_eff;
        sel_pc_start_o = (state_q == BOOT);
        load_pc_o      = (state_q == BOOT) || issue_ready_o || redirect_eff;
        flush_o        = flush_q;
        epoch_o        = epoch_q;
    end

    // Startup sequencing with a down-counter over the fetch latency.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            BOOT: begin
                state_d    = FILL;
                fill_cnt_d = CNT_W'(FETCH_LAT - 1);
            end
            FILL: begin
                if (fill_cnt_q == '0) state_d = RUN;
                else                  fill_cnt_d = fill_cnt_q - CNT_W'(1);
            end
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Epoch advance and one-cycle flush pulse following a redirect.
    always_comb begin
        epoch_d = redirect_eff ? epoch_q + EPOCH_W'(1) : epoch_q;
        flush_d = redirect_eff;
    end

    // Scoreboard shift; stage 0 takes the accepted issue or a bubble.
    always_comb begin
        sb_d[0] = '0;
        if (accept) begin
            sb_d[0].valid           = 1'b1;
            sb_d[0].wr              = issue_wr_i;
            sb_d[0].ld              = issue_ld_i;
            sb_d[0].rd[REG_AW-1:0]  = issue_rd_i;
        end
        for (int k = 1; k < N_STAGES; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fill_cnt_q <= '0;
            epoch_q    <= '0;
            flush_q    <= 1'b0;
            for (int k = 0; k < N_STAGES; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            epoch_q    <= epoch_d;
            flush_q    <= flush_d;
            for (int k = 0; k < N_STAGES; k++) begin
                sb_q[k] <= sb_d[k];
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating event counters; redirects ignored during startup are not counted.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_o && (perf_stall_q != '1))      perf_stall_d = perf_stall_q + 32'd1;
        if (redirect_eff && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed vector table, randomized run
// against a history-based reference model, and epoch-wrap / mid-run reset sequences.
module tb_pipeline_hazard_unit;

    localparam int N_STAGES  = 4;
    localparam int REG_AW    = 4;
    localparam int N_SRC     = 3;
    localparam int LOAD_LAT  = 2;
    localparam int FETCH_LAT = 2;
    localparam int EPOCH_W   = 2;
    localparam int SELW      = 3;
    localparam int PC_REG    = 15;

    logic                    clk;
    logic                    rst_n;
    logic                    issue_valid_i;
    logic [EPOCH_W-1:0]      issue_epoch_i;
    logic                    issue_wr_i;
    logic                    issue_ld_i;
    logic [REG_AW-1:0]       issue_rd_i;
    logic [N_SRC*REG_AW-1:0] src_addr_i;
    logic [N_SRC-1:0]        src_used_i;
    logic                    redirect_i;
    logic                    sel_pc_start_o;
    logic                    load_pc_o;
    logic                    issue_ready_o;
    logic                    stall_o;
    logic                    flush_o;
    logic [EPOCH_W-1:0]      epoch_o;
    logic [N_SRC*SELW-1:0]   fwd_sel_o;

    pipeline_hazard_unit #(
        .N_STAGES  (N_STAGES),
        .REG_AW    (REG_AW),
        .N_SRC     (N_SRC),
        .LOAD_LAT  (LOAD_LAT),
        .FETCH_LAT (FETCH_LAT),
        .EPOCH_W   (EPOCH_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid_i  (issue_valid_i),
        .issue_epoch_i  (issue_epoch_i),
        .issue_wr_i     (issue_wr_i),
        .issue_ld_i     (issue_ld_i),
        .issue_rd_i     (issue_rd_i),
        .src_addr_i     (src_addr_i),
        .src_used_i     (src_used_i),
        .redirect_i     (redirect_i),
        .sel_pc_start_o (sel_pc_start_o),
        .load_pc_o      (load_pc_o),
        .issue_ready_o  (issue_ready_o),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .epoch_o        (epoch_o),
        .fwd_sel_o      (fwd_sel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        issue_valid_i = 1'b0;
        issue_epoch_i = '0;
        issue_wr_i    = 1'b0;
        issue_ld_i    = 1'b0;
        issue_rd_i    = '0;
        src_addr_i    = '0;
        src_used_i    = '0;
        redirect_i    = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Accepted writers remembered with the cycle number they were issued in;
    // a writer is forwardable from stage (now - issue_cycle - 1) while that
    // age is below N_STAGES.
    typedef struct {
        int cyc;
        int rd;
        bit ld;
    } wr_rec_t;

    wr_rec_t inflight[$];
    int      m_now;
    int      m_since;
    int      m_epoch;
    bit      m_flush;

    bit                   e_ready, e_stall, e_lpc, e_selpc, e_redir;
    logic [N_SRC*SELW-1:0] e_fwd;

    task automatic model_reset();
        inflight.delete();
        m_now   = 0;
        m_since = 0;
        m_epoch = 0;
        m_flush = 0;
    endtask

    task automatic model_eval();
        bit run;
        bit any_ld;
        run    = (m_since >= 1 + FETCH_LAT);
        any_ld = 0;
        e_fwd  = '0;
        for (int j = 0; j < N_SRC; j++) begin
            int a;
            a = int'(src_addr_i[j*REG_AW +: REG_AW]);
            if (src_used_i[j] && a != PC_REG) begin
                for (int i = inflight.size() - 1; i >= 0; i--) begin
                    int age;
                    age = m_now - inflight[i].cyc - 1;
                    if (age < N_STAGES && inflight[i].rd == a) begin
                        e_fwd[j*SELW +: SELW] = SELW'(age + 1);
                        if (inflight[i].ld && age < LOAD_LAT) any_ld = 1;
                        break;
                    end
                end
            end
        end
        e_redir = redirect_i && run;
        e_stall = any_ld && !e_redir;
        e_ready = run && !e_stall;
        e_selpc = (m_since == 0);
        e_lpc   = e_selpc || e_ready || e_redir;
    endtask

    task automatic model_edge();
        if (issue_valid_i && e_ready && int'(issue_epoch_i) == m_epoch && !e_redir && issue_wr_i)
            inflight.push_back('{cyc: m_now, rd: int'(issue_rd_i), ld: issue_ld_i});
        m_flush = e_redir;
        if (e_redir) m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
        m_now++;
        m_since++;
        while (inflight.size() > 0 && (m_now - inflight[0].cyc - 1) >= N_STAGES)
            void'(inflight.pop_front());
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit v; int ep; bit wr; bit ld; int rd; int src; bit used; bit redir;
        bit e_ready; bit e_stall; bit e_lpc; int e_sel; bit e_flush; int e_ep; bit e_selpc;
    } vec_t;

    vec_t tbl[23];

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          v ep wr ld rd src used rdr | rdy stl lpc sel fl ep spc
        tbl[0]  = '{0, 0, 0, 0, 0, 0,  0,  0,   0,  0,  1,  0,  0, 0, 1};
        tbl[1]  = '{0, 0, 0, 0, 0, 0,  0,  0,   0,  0,  0,  0,  0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0,  0,  1,   0,  0,  0,  0,  0, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 1, 0,  0,  0,   1,  0,  1,  0,  0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 1,  1,  0,   1,  0,  1,  1,  0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 1,  1,  0,   1,  0,  1,  2,  0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0,  0,  0,   1,  0,  1,  0,  0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 1,  1,  0,   1,  0,  1,  4,  0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 1,  1,  0,   1,  0,  1,  0,  0, 0, 0};
        tbl[9]  = '{1, 0, 1, 1, 2, 0,  0,  0,   1,  0,  1,  0,  0, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 2,  1,  0,   0,  1,  0,  1,  0, 0, 0};
        tbl[11] = '{1, 0, 0, 0, 0, 2,  1,  0,   0,  1,  0,  2,  0, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 2,  1,  0,   1,  0,  1,  3,  0, 0, 0};
        tbl[13] = '{1, 0, 1, 0, 3, 0,  0,  0,   1,  0,  1,  0,  0, 0, 0};
        tbl[14] = '{1, 0, 1, 0, 15,0,  0,  0,   1,  0,  1,  0,  0, 0, 0};
        tbl[15] = '{1, 0, 1, 0, 3, 0,  0,  0,   1,  0,  1,  0,  0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 3,  1,  0,   1,  0,  1,  1,  0, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 15, 1,  0,   1,  0,  1,  0,  0, 0, 0};
        tbl[18] = '{1, 0, 1, 1, 5, 0,  0,  0,   1,  0,  1,  0,  0, 0, 0};
        tbl[19] = '{1, 0, 0, 0, 0, 5,  1,  1,   1,  0,  1,  1,  0, 0, 0};
        tbl[20] = '{1, 0, 1, 0, 6, 0,  0,  0,   1,  0,  1,  0,  1, 1, 0};
        tbl[21] = '{1, 1, 1, 0, 7, 6,  1,  0,   1,  0,  1,  0,  0, 1, 0};
        tbl[22] = '{0, 0, 0, 0, 0, 7,  1,  0,   1,  0,  1,  1,  0, 1, 0};

        do_reset();
        for (int r = 0; r < 23; r++) begin
            issue_valid_i = tbl[r].v;
            issue_epoch_i = EPOCH_W'(tbl[r].ep);
            issue_wr_i    = tbl[r].wr;
            issue_ld_i    = tbl[r].ld;
            issue_rd_i    = REG_AW'(tbl[r].rd);
            src_addr_i    = {8'h00, REG_AW'(tbl[r].src)};
            src_used_i    = {2'b00, tbl[r].used};
            redirect_i    = tbl[r].redir;
            #3;
            check($sformatf("vec%0d_ready", r), 32'(issue_ready_o), 32'(tbl[r].e_ready));
            check($sformatf("vec%0d_stall", r), 32'(stall_o), 32'(tbl[r].e_stall));
            check($sformatf("vec%0d_load_pc", r), 32'(load_pc_o), 32'(tbl[r].e_lpc));
            check($sformatf("vec%0d_fwd0", r), 32'(fwd_sel_o[SELW-1:0]), 32'(tbl[r].e_sel));
            check($sformatf("vec%0d_flush", r), 32'(flush_o), 32'(tbl[r].e_flush));
            check($sformatf("vec%0d_epoch", r), 32'(epoch_o), 32'(tbl[r].e_ep));
            check($sformatf("vec%0d_sel_pc", r), 32'(sel_pc_start_o), 32'(tbl[r].e_selpc));
            @(posedge clk);
            #1;
        end

        // ---------------- randomized run against the model ----------------
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            issue_valid_i = ($urandom_range(0, 3) != 0);
            issue_epoch_i = ($urandom_range(0, 5) == 0) ? EPOCH_W'($urandom) : EPOCH_W'(m_epoch);
            issue_wr_i    = ($urandom_range(0, 3) != 0);
            issue_ld_i    = ($urandom_range(0, 2) == 0);
            issue_rd_i    = ($urandom_range(0, 9) == 0) ? REG_AW'(PC_REG) : REG_AW'($urandom_range(0, 5));
            for (int j = 0; j < N_SRC; j++) begin
                src_addr_i[j*REG_AW +: REG_AW] = ($urandom_range(0, 9) == 0) ? REG_AW'(PC_REG)
                                                 : REG_AW'($urandom_range(0, 5));
                src_used_i[j] = ($urandom_range(0, 2) != 0);
            end
            redirect_i = ($urandom_range(0, 15) == 0);
            #3;
            model_eval();
            check("rnd_ready", 32'(issue_ready_o), 32'(e_ready));
            check("rnd_stall", 32'(stall_o), 32'(e_stall));
            check("rnd_load_pc", 32'(load_pc_o), 32'(e_lpc));
            check("rnd_sel_pc", 32'(sel_pc_start_o), 32'(e_selpc));
            check("rnd_flush", 32'(flush_o), 32'(m_flush));
            check("rnd_epoch", 32'(epoch_o), 32'(m_epoch));
            check("rnd_fwd", 32'(fwd_sel_o), 32'(e_fwd));
            @(posedge clk);
            model_edge();
            #1;
        end

        // ---------------- epoch wrap over four redirects ----------------
        do_reset();
        repeat (1 + FETCH_LAT) begin
            @(posedge clk);
            #1;
        end
        #3;
        check("wrap_in_run", 32'(issue_ready_o), 32'd1);
        redirect_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) redirect_i = 1'b0;
            #3;
            check($sformatf("wrap_epoch%0d", i), 32'(epoch_o), 32'(i % 4));
            check($sformatf("wrap_flush%0d", i), 32'(flush_o), 32'd1);
        end

        // ---------------- reset asserted mid-run ----------------
        redirect_i = 1'b1;
        @(posedge clk);
        #1;
        redirect_i    = 1'b0;
        issue_valid_i = 1'b1;
        issue_epoch_i = 2'd1;
        issue_wr_i    = 1'b1;
        issue_rd_i    = 4'd4;
        #3;
        check("mid_epoch_before", 32'(epoch_o), 32'd1);
        @(posedge clk);
        #1;
        drive_idle();
        src_addr_i = {8'h00, 4'd4};
        src_used_i = 3'b001;
        #3;
        check("mid_fwd_before", 32'(fwd_sel_o[SELW-1:0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_load_pc", 32'(load_pc_o), 32'd1);
        check("rst_sel_pc", 32'(sel_pc_start_o), 32'd1);
        check("rst_epoch", 32'(epoch_o), 32'd0);
        check("rst_ready", 32'(issue_ready_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_fwd", 32'(fwd_sel_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        check("boot_sel_pc", 32'(sel_pc_start_o), 32'd1);
        check("boot_fwd", 32'(fwd_sel_o), 32'd0);
        check("boot_epoch", 32'(epoch_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
